// File: rtl/seq_sub_bla_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and
// the counter-width helper.
package seq_sub_bla_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Counter width for NIB nibbles; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/seq_sub_bla_bl4.sv
// Combinational 4-bit borrow look-ahead slice: d = a - b - bi, bo = borrow out.
module bl4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bi,
   output logic [3:0] d,
   output logic       bo
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] w;

   // Generate/propagate terms and two-level borrow look-ahead for w1..w4.
   always_comb begin
      g    = ~a & b;
      p    = ~(a ^ b);
      w[0] = bi;
      w[1] = g[0] | (p[0] & bi);
      w[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
      w[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & bi);
      w[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);
      d    = a ^ b ^ w[3:0];
      bo   = w[4];
   end

endmodule

// File: rtl/seq_sub_bla.sv
// Multi-cycle subtractor d = a - b - bi, one nibble per clock through a
// borrow look-ahead slice with the borrow registered between nibbles.
module seq_sub_bla
   import seq_sub_bla_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             v,
   output logic             z,
   output logic             n
);

   localparam int unsigned NIB   = WIDTH / 4;
   localparam int unsigned CNT_W = cnt_width(NIB);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic             brw_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] d_q;
   logic             bo_q;
   logic             v_q;
   logic             z_q;
   logic             n_q;
   logic             busy_q;
   logic             done_q;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       nib_d;
   logic             nib_bo;
   logic [WIDTH+3:0] cat_d;
   logic [WIDTH-1:0] sum_d;
   logic             v_d;

   // Select the nibble of each operand addressed by the counter.
   always_comb begin
      a_nib = ra_q[{cnt_q, 2'b00} +: 4];
      b_nib = rb_q[{cnt_q, 2'b00} +: 4];
   end

   bl4 u_bl4 (
      .a  (a_nib),
      .b  (b_nib),
      .bi (brw_q),
      .d  (nib_d),
      .bo (nib_bo)
   );

   // Partial result is a right-shifting register: each new nibble enters at
   // the top, so after NIB steps nibble 0 sits at bit 0 and the value is the
   // complete difference.
   always_comb begin
      cat_d = {nib_d, sum_q};
      sum_d = cat_d[WIDTH+3:4];
      v_d   = (ra_q[WIDTH-1] ^ rb_q[WIDTH-1]) & (ra_q[WIDTH-1] ^ sum_d[WIDTH-1]);
   end

   // Control FSM, operand/borrow registers and registered result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         brw_q   <= 1'b0;
         sum_q   <= '0;
         d_q     <= '0;
         bo_q    <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  ra_q    <= a;
                  rb_q    <= b;
                  brw_q   <= bi;
                  cnt_q   <= '0;
                  sum_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               brw_q <= nib_bo;
               sum_q <= sum_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  d_q     <= sum_d;
                  bo_q    <= nib_bo;
                  v_q     <= v_d;
                  z_q     <= ~|sum_d;
                  n_q     <= sum_d[WIDTH-1];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign bo   = bo_q;
   assign v    = v_q;
   assign z    = z_q;
   assign n    = n_q;

endmodule

// File: tb/tb_seq_sub_bla.sv
// Self-checking bench for seq_sub_bla (WIDTH=32) against an arithmetic model.
module tb_seq_sub_bla;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        bi;
   logic        busy;
   logic        done;
   logic [31:0] d;
   logic        bo;
   logic        v;
   logic        z;
   logic        n;

   int total = 0;
   int bad   = 0;

   // Expected results of the op in flight and the value d must hold meanwhile.
   logic [31:0] exp_d;
   logic        exp_bo, exp_v, exp_z, exp_n;
   logic [31:0] prev_d;

   seq_sub_bla #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo),
      .v     (v),
      .z     (z),
      .n     (n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbi);
      longint      ua, ub, diff, sa, sb, sres;
      logic [63:0] dv;
      ua   = longint'(ma);
      ub   = longint'(mb);
      diff = ua - ub - longint'(mbi);
      dv   = diff;
      sa   = longint'($signed(ma));
      sb   = longint'($signed(mb));
      sres = sa - sb - longint'(mbi);
      exp_d  = dv[31:0];
      exp_bo = (diff < 0);
      exp_v  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      exp_z  = (exp_d == 32'd0);
      exp_n  = exp_d[31];
   endtask

   // Called at a negedge: present an op, let the next posedge accept it.
   task automatic launch(input logic [31:0] la, input logic [31:0] lb, input logic lbi);
      model(la, lb, lbi);
      a     = la;
      b     = lb;
      bi    = lbi;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_clear_after_accept", {63'd0, done}, 64'd0);
   endtask

   // Wait for done, scrambling inputs meanwhile; optional start pulse at a RUN cycle.
   task automatic wait_done(input string tag, input int glitch_cyc);
      int   lat;
      logic busy_ok, hold_ok;
      lat     = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (d !== prev_d) hold_ok = 1'b0;
         a     = $urandom;
         b     = $urandom;
         bi    = 1'($urandom);
         start = (lat == glitch_cyc);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 64'(lat), 64'd8);
      chk({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
      chk({tag, "_d_hold"}, {63'd0, hold_ok}, 64'd1);
      chk({tag, "_d"}, {32'd0, d}, {32'd0, exp_d});
      chk({tag, "_flags"}, {60'd0, bo, v, z, n}, {60'd0, exp_bo, exp_v, exp_z, exp_n});
      chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
      prev_d = exp_d;
   endtask

   task automatic run_op(input string tag, input logic [31:0] la, input logic [31:0] lb,
                         input logic lbi);
      launch(la, lb, lbi);
      wait_done(tag, -1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int          seen;
      logic [31:0] ra, rb;
      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      bi     = 1'b0;
      prev_d = '0;
      repeat (2) @(negedge clk);
      chk("reset_outs", {28'd0, d, busy, done, bo, v, z, n}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("basic", 32'h0000_0005, 32'h0000_0003, 1'b0);
      run_op("ripple0", 32'h0000_0000, 32'h0000_0001, 1'b0);
      run_op("ripple_bi", 32'h0000_0010, 32'h0000_0010, 1'b1);
      run_op("ovf", 32'h8000_0000, 32'h0000_0001, 1'b0);
      run_op("zero", 32'h1234_5678, 32'h1234_5678, 1'b0);
      run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("max_bi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

      // Start pulse mid-run is ignored; start during DONE is taken back-to-back.
      launch(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
      wait_done("glitch", 3);
      launch(32'h0000_0100, 32'h0000_0200, 1'b0);
      wait_done("b2b", -1);
      @(negedge clk);
      chk("b2b_done_pulse", {63'd0, done}, 64'd0);

      // Reset mid-run aborts with no done.
      launch(32'h5555_AAAA, 32'h1111_2222, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_outs", {28'd0, d, busy, done, bo, v, z, n}, 64'd0);
      rst    = 1'b0;
      prev_d = '0;
      seen   = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      run_op("after_abort", 32'h0000_1000, 32'h0000_0FFF, 1'b1);

      // Randomized ops, biased toward boundary patterns.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: ra = {ra[31], 31'd0};
            2: rb = ~32'd0 ^ (32'd1 << $urandom_range(0, 31));
            default: ;
         endcase
         run_op("rand", ra, rb, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
